// File: rtl/arith_pkg.sv
// Shared types and helpers for the pipelined saturating add/sub unit.
// Op encoding and the signed clamp limits used by the arithmetic core.
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

    // Largest positive two's complement value of width w (011..1), zero-extended to 32 bits.
    function automatic logic [31:0] sat_max(input int w);
        sat_max = (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // Most negative two's complement value of width w (100..0), zero-extended to 32 bits.
    function automatic logic [31:0] sat_min(input int w);
        sat_min = 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/arith_core.sv
// Combinational signed add/subtract with overflow detect and optional clamp.
// Both operands are sign-extended one bit so the carry-out bit exposes overflow directly.
module arith_core
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    input  logic             sat,
    output logic [WIDTH-1:0] res,
    output logic             ov
);

    localparam logic [31:0] MAX32 = sat_max(WIDTH);
    localparam logic [31:0] MIN32 = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] MAX_VAL = MAX32[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MIN_VAL = MIN32[WIDTH-1:0];

    logic [WIDTH:0] x_ext;
    logic [WIDTH:0] y_ext;
    logic [WIDTH:0] full;

    assign x_ext = {x[WIDTH-1], x};
    assign y_ext = {y[WIDTH-1], y};
    assign full  = sub ? (x_ext - y_ext) : (x_ext + y_ext);
    assign ov    = full[WIDTH] ^ full[WIDTH-1];

    // The extended sign bit tells which way the true result escaped the range.
    always_comb begin
        res = full[WIDTH-1:0];
        if (sat && ov) begin
            res = full[WIDTH] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/arith_pipe_sat.sv
// Registered signed add/sub/accumulate unit with valid/ready handshake,
// optional saturation and a sticky overflow flag. Latency one cycle, no skid buffer.
module arith_pipe_sat
    import arith_pkg::*;
#(
    parameter int   WIDTH   = 16,
    parameter logic SAT_DEF = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sat_wr,
    input  logic             sat_in,
    input  logic             clr_ov,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] result,
    output logic             ov,
    output logic             sticky_ov,
    output logic [WIDTH-1:0] acc
);

    logic             out_vld_reg;
    logic [WIDTH-1:0] result_reg;
    logic             ov_reg;
    logic             sticky_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             sat_mode_reg;

    logic             accept;
    logic             acc_upd;
    logic [WIDTH-1:0] core_x;
    logic [WIDTH-1:0] core_y;
    logic             core_sub;
    logic [WIDTH-1:0] result_next;
    logic             ov_next;

    assign in_rdy  = ~out_vld_reg | out_rdy;
    assign accept  = in_vld & in_rdy;

    // LOAD is routed as A + 0, which can never overflow.
    always_comb begin
        core_x   = A;
        core_y   = B;
        core_sub = 1'b0;
        acc_upd  = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                core_x = A;
                core_y = B;
            end
            OP_SUB: begin
                core_sub = 1'b1;
            end
            OP_ACC: begin
                core_x  = acc_reg;
                core_y  = A;
                acc_upd = 1'b1;
            end
            OP_LOAD: begin
                core_x  = A;
                core_y  = '0;
                acc_upd = 1'b1;
            end
            default: ;
        endcase
    end

    arith_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x   (core_x),
        .y   (core_y),
        .sub (core_sub),
        .sat (sat_mode_reg),
        .res (result_next),
        .ov  (ov_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_reg  <= 1'b0;
            result_reg   <= '0;
            ov_reg       <= 1'b0;
            sticky_reg   <= 1'b0;
            acc_reg      <= '0;
            sat_mode_reg <= SAT_DEF;
        end else begin
            if (accept) begin
                out_vld_reg <= 1'b1;
                result_reg  <= result_next;
                ov_reg      <= ov_next;
                if (acc_upd) begin
                    acc_reg <= result_next;
                end
            end else if (out_rdy) begin
                out_vld_reg <= 1'b0;
            end

            // A fresh overflow outranks a concurrent clear.
            if (accept && ov_next) begin
                sticky_reg <= 1'b1;
            end else if (clr_ov) begin
                sticky_reg <= 1'b0;
            end

            if (sat_wr) begin
                sat_mode_reg <= sat_in;
            end
        end
    end

    assign out_vld   = out_vld_reg;
    assign result    = result_reg;
    assign ov        = ov_reg;
    assign sticky_ov = sticky_reg;
    assign acc       = acc_reg;

endmodule

// File: tb/tb_arith_pipe_sat.sv
// Self-checking bench for arith_pipe_sat at WIDTH=8: directed vector table,
// hand-written handshake/reset sequences, then random traffic against an integer model.
module tb_arith_pipe_sat;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_vld = 1'b0;
    logic         in_rdy;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         sat_wr = 1'b0;
    logic         sat_in = 1'b0;
    logic         clr_ov = 1'b0;
    logic         out_vld;
    logic         out_rdy = 1'b1;
    logic [W-1:0] result;
    logic         ov;
    logic         sticky_ov;
    logic [W-1:0] acc;

    int checks = 0;
    int errors = 0;

    arith_pipe_sat #(
        .WIDTH   (W),
        .SAT_DEF (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .op        (op),
        .A         (A),
        .B         (B),
        .sat_wr    (sat_wr),
        .sat_in    (sat_in),
        .clr_ov    (clr_ov),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .result    (result),
        .ov        (ov),
        .sticky_ov (sticky_ov),
        .acc       (acc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, range test, then clamp or wrap.
    function automatic void ref_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] accv, input bit sat,
                                   output logic [7:0] r, output bit ovf);
        int sa, sb, sacc, full;
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        sacc = int'($signed(accv));
        case (o)
            2'd0:    full = sa + sb;
            2'd1:    full = sa - sb;
            2'd2:    full = sacc + sa;
            default: full = sa;
        endcase
        ovf = (full > 127) || (full < -128);
        if (ovf && sat) r = (full > 0) ? 8'h7F : 8'h80;
        else            r = full[7:0];
    endfunction

    task automatic set_sat(input logic v);
        @(negedge clk);
        sat_wr = 1'b1;
        sat_in = v;
        @(negedge clk);
        sat_wr = 1'b0;
    endtask

    // One accepted op with the consumer ready; outputs are sampled on the following negedge.
    task automatic apply(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, input logic clr);
        @(negedge clk);
        op      = o;
        A       = a;
        B       = b;
        in_vld  = 1'b1;
        out_rdy = 1'b1;
        clr_ov  = clr;
        @(negedge clk);
        in_vld = 1'b0;
        clr_ov = 1'b0;
        $display("txn op=%0d A=%02h B=%02h -> result=%02h ov=%0b acc=%02h sticky=%0b",
                 o, a, b, result, ov, acc, sticky_ov);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       sat;
        logic [7:0] res;
        logic       ov;
        logic [7:0] acc;
    } vec_t;

    vec_t tbl [10];

    // Random-phase model state.
    logic [7:0] m_res, m_acc, r_tmp;
    bit         m_vld, m_ov, m_sticky, m_sat, o_tmp, m_rdy;

    initial begin
        logic cur_sat;
        logic exp_sticky;

        tbl[0] = '{2'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b1, 8'h00};
        tbl[1] = '{2'd0, 8'h7F, 8'h01, 1'b1, 8'h7F, 1'b1, 8'h00};
        tbl[2] = '{2'd1, 8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 8'h00};
        tbl[3] = '{2'd1, 8'h00, 8'h80, 1'b1, 8'h7F, 1'b1, 8'h00};
        tbl[4] = '{2'd1, 8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 8'h00};
        tbl[5] = '{2'd1, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 8'h00};
        tbl[6] = '{2'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[7] = '{2'd3, 8'h10, 8'h55, 1'b1, 8'h10, 1'b0, 8'h10};
        tbl[8] = '{2'd2, 8'h70, 8'h00, 1'b1, 8'h7F, 1'b1, 8'h7F};
        tbl[9] = '{2'd2, 8'h81, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_vld", 32'(out_vld), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_ov", 32'(ov), 32'd0);
        check("reset_sticky", 32'(sticky_ov), 32'd0);
        check("reset_acc", 32'(acc), 32'd0);
        check("reset_in_rdy", 32'(in_rdy), 32'd1);

        cur_sat    = 1'b0;
        exp_sticky = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].sat != cur_sat) begin
                set_sat(tbl[i].sat);
                cur_sat = tbl[i].sat;
            end
            apply(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0);
            exp_sticky = exp_sticky | tbl[i].ov;
            check($sformatf("vec%0d_result", i), 32'(result), 32'(tbl[i].res));
            check($sformatf("vec%0d_ov", i), 32'(ov), 32'(tbl[i].ov));
            check($sformatf("vec%0d_acc", i), 32'(acc), 32'(tbl[i].acc));
            check($sformatf("vec%0d_sticky", i), 32'(sticky_ov), 32'(exp_sticky));
            check($sformatf("vec%0d_out_vld", i), 32'(out_vld), 32'd1);
        end

        // Backpressure: ACC held off for three cycles, then consumed exactly once.
        @(negedge clk);
        op = 2'd3; A = 8'h05; in_vld = 1'b1; out_rdy = 1'b0;
        @(negedge clk);
        op = 2'd2; A = 8'h01;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d_in_rdy", i), 32'(in_rdy), 32'd0);
            check($sformatf("bp%0d_result", i), 32'(result), 32'h05);
            check($sformatf("bp%0d_acc", i), 32'(acc), 32'h05);
            check($sformatf("bp%0d_out_vld", i), 32'(out_vld), 32'd1);
            @(negedge clk);
        end
        out_rdy = 1'b1;
        #1;
        check("bp_release_in_rdy", 32'(in_rdy), 32'd1);
        @(negedge clk);
        in_vld = 1'b0;
        check("bp_acc_once", 32'(acc), 32'h06);
        check("bp_result", 32'(result), 32'h06);
        @(negedge clk);
        check("bp_acc_stable", 32'(acc), 32'h06);
        check("bp_out_vld_drop", 32'(out_vld), 32'd0);
        $display("txn backpressure ACC -> acc=%02h", acc);

        // Clear alone, then clear racing a fresh overflow.
        @(negedge clk);
        clr_ov = 1'b1;
        @(negedge clk);
        clr_ov = 1'b0;
        check("clr_sticky", 32'(sticky_ov), 32'd0);
        apply(2'd0, 8'h7F, 8'h01, 1'b1);
        check("clr_vs_ov_sticky", 32'(sticky_ov), 32'd1);

        // Async reset while a result is pending.
        @(negedge clk);
        op = 2'd3; A = 8'h33; in_vld = 1'b1; out_rdy = 1'b0;
        @(negedge clk);
        in_vld = 1'b0;
        check("pre_rst_out_vld", 32'(out_vld), 32'd1);
        check("pre_rst_acc", 32'(acc), 32'h33);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_vld", 32'(out_vld), 32'd0);
        check("async_rst_acc", 32'(acc), 32'd0);
        check("async_rst_sticky", 32'(sticky_ov), 32'd0);
        check("async_rst_result", 32'(result), 32'd0);
        $display("txn async reset -> out_vld=%0b acc=%02h", out_vld, acc);
        @(negedge clk);
        rst = 1'b0;
        out_rdy = 1'b1;

        // Random traffic against the integer model.
        m_vld = 0; m_res = 8'h00; m_ov = 0; m_sticky = 0; m_acc = 8'h00; m_sat = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            in_vld  = ($urandom_range(0, 3) != 0);
            op      = 2'($urandom_range(0, 3));
            A       = 8'($urandom);
            B       = 8'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            sat_wr  = ($urandom_range(0, 7) == 0);
            sat_in  = 1'($urandom);
            clr_ov  = ($urandom_range(0, 7) == 0);
            #1;
            m_rdy = !m_vld || out_rdy;
            check("rnd_in_rdy", 32'(in_rdy), 32'(m_rdy));
            @(posedge clk);
            if (in_vld && m_rdy) begin
                ref_op(op, A, B, m_acc, m_sat, r_tmp, o_tmp);
                m_vld = 1; m_res = r_tmp; m_ov = o_tmp;
                if (op == 2'd2 || op == 2'd3) m_acc = r_tmp;
                if (o_tmp) m_sticky = 1;
                else if (clr_ov) m_sticky = 0;
                $display("txn rnd op=%0d A=%02h B=%02h sat=%0b -> exp %02h ov=%0b", op, A, B, m_sat, r_tmp, o_tmp);
            end else begin
                if (out_rdy) m_vld = 0;
                if (clr_ov) m_sticky = 0;
            end
            if (sat_wr) m_sat = sat_in;
            @(negedge clk);
            check("rnd_out_vld", 32'(out_vld), 32'(m_vld));
            check("rnd_result", 32'(result), 32'(m_res));
            check("rnd_ov", 32'(ov), 32'(m_ov));
            check("rnd_acc", 32'(acc), 32'(m_acc));
            check("rnd_sticky", 32'(sticky_ov), 32'(m_sticky));
            in_vld = 1'b0; sat_wr = 1'b0; clr_ov = 1'b0; out_rdy = 1'b0;
            // Idle half-cycle already elapsed; model the idle edge that follows.
            @(posedge clk);
            #1;
            check("rnd_idle_out_vld", 32'(out_vld), 32'(m_vld));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
